// File: rtl/jk_bank_ctrl.sv
// Sequencer for a bank of JK flip-flops: takes one command at a time and drives J/K
// to clear, set, load, toggle or count the bank, then pulses done once q_in shows the result.
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] t_up, t_down;
    logic             accept;
    logic             is_count_op;

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign busy        = ((state_q == EXEC) || (state_q == COUNT)) && !rst;
    assign done        = (state_q == DONE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

    // Ripple toggle enables for a synchronous binary counter built from the bank itself.
    always_comb begin
        t_up      = '0;
        t_down    = '0;
        t_up[0]   = 1'b1;
        t_down[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i]   = t_up[i-1] & q_in[i-1];
            t_down[i] = t_down[i-1] & ~q_in[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        steps_d = steps_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    steps_d = cmd_steps;
                    if (is_count_op && (cmd_steps != '0)) begin
                        state_d = COUNT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: state_d = DONE;
            COUNT: begin
                steps_d = steps_q - CNT_W'(1);
                if (steps_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset forces a clear onto the bank on the same edge the controller resets.
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (rst) begin
            k_out = '1;
        end else begin
            case (state_q)
                EXEC: begin
                    case (op_q)
                        OP_CLEAR:  k_out = '1;
                        OP_SET:    j_out = '1;
                        OP_LOAD: begin
                            j_out = data_q;
                            k_out = ~data_q;
                        end
                        OP_TOGGLE: begin
                            j_out = data_q;
                            k_out = data_q;
                        end
                        default: begin
                            j_out = '0;
                            k_out = '0;
                        end
                    endcase
                end
                COUNT: begin
                    if (op_q == OP_UP) begin
                        j_out = t_up;
                        k_out = t_up;
                    end else begin
                        j_out = t_down;
                        k_out = t_down;
                    end
                end
                default: begin
                    j_out = '0;
                    k_out = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            steps_q <= steps_d;
        end
    end

endmodule
